// File: rtl/sw_debounce_bank.sv
// sw_debounce_bank: per-channel synchroniser, stability debouncer, edge pulses, toggle latch and auto-repeat
module sw_debounce_bank #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 20,
  parameter int               STABLE_CNT  = 1000000,
  parameter logic [WIDTH-1:0] REP_MASK    = '0,
  parameter int               REP_DELAY   = 500000,
  parameter int               REP_PERIOD  = 100000
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] SW_IN,
  output logic [WIDTH-1:0] SW_OK,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] TOGGLE,
  output logic [WIDTH-1:0] REPEAT
);
  localparam logic [CNT_W-1:0] STB_LIM = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REP_PERIOD - 1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ok_q, ok_d, rise_q, rise_d, fall_q, fall_d, tog_q, tog_d, s;
    // shift the raw level in, count consecutive disagreeing cycles and commit after STABLE_CNT
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], SW_IN[i]};
      s      = sync_q[SYNC_STAGES-1];
      cnt_d  = (s == ok_q || cnt_q == STB_LIM) ? '0 : cnt_q + 1'b1;
      ok_d   = (s != ok_q && cnt_q == STB_LIM) ? s : ok_q;
      rise_d = ok_d & ~ok_q;
      fall_d = ~ok_d & ok_q;
      tog_d  = tog_q ^ rise_d;
    end
    // channel state registers; pulses are registered alongside the level they announce
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        sync_q <= '0;
        cnt_q  <= '0;
        ok_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        tog_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        ok_q   <= ok_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        tog_q  <= tog_d;
      end
    end
    assign SW_OK[i]  = ok_q;
    assign RISE[i]   = rise_q;
    assign FALL[i]   = fall_q;
    assign TOGGLE[i] = tog_q;
    if (REP_MASK[i]) begin : g_rep
      logic [CNT_W-1:0] rcnt_q, rcnt_d;
      logic             per_q, per_d, rep_q, rep_d, hold, hit;
      // count held cycles; first pulse after REP_DELAY, then every REP_PERIOD by restarting the count
      always_comb begin
        hold   = ok_q & ok_d;
        hit    = hold && (rcnt_q == (per_q ? PER_LIM : DLY_LIM));
        rcnt_d = (!hold || hit) ? '0 : rcnt_q + 1'b1;
        per_d  = hold & (per_q | hit);
        rep_d  = hit;
      end
      // repeat counter, phase flag and pulse registers
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          rcnt_q <= '0;
          per_q  <= 1'b0;
          rep_q  <= 1'b0;
        end else begin
          rcnt_q <= rcnt_d;
          per_q  <= per_d;
          rep_q  <= rep_d;
        end
      end
      assign REPEAT[i] = rep_q;
    end else begin : g_norep
      assign REPEAT[i] = 1'b0;
    end
  end
endmodule
